id_ex_stage: RTL and testbench

- Pipeline register between decode/register-read and execute.
- Captures the operands returned by the three-port register file (rd1/rd2) together with decoded instruction fields.
- Applies a same-cycle writeback bypass, because a register-file write only becomes visible after the clock edge.
- Keeps held operands coherent while the stage is stalled, and presents a valid/ready handshake to both neighbouring stages.

---
 rtl/id_ex_stage.sv | 117 +++++++++++
 tb/tb_id_ex_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Captures register-file operands and decoded fields from decode. A writeback
// landing on the same edge is bypassed into the captured operands, and held
// operands are refreshed by writebacks while execute stalls. Decode and
// execute each see a valid/ready handshake, and a saturating counter tracks
// stalled cycles.
module id_ex_stage #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [5:0]        id_rs1,
    input  logic [5:0]        id_rs2,
    input  logic [5:0]        id_rd,
    input  logic [31:0]       rf_rd1,
    input  logic [31:0]       rf_rd2,
    input  logic              wb_we,
    input  logic [5:0]        wb_rd,
    input  logic [31:0]       wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [5:0]        ex_rs1,
    output logic [5:0]        ex_rs2,
    output logic [5:0]        ex_rd,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Register identity uses the low five index bits; x0 never takes a bypass.
    function automatic logic wb_hits(input logic       we,
                                     input logic [5:0] wr_idx,
                                     input logic [5:0] rs_idx);
        return we && (wr_idx[4:0] == rs_idx[4:0]) && (rs_idx[4:0] != 5'd0);
    endfunction

    // Operand as it will look architecturally once this edge's write lands.
    function automatic logic [31:0] fresh_operand(input logic [5:0]  rs_idx,
                                                  input logic [31:0] rf_data);
        return wb_hits(wb_we, wb_rd, rs_idx) ? wb_data : rf_data;
    endfunction

    // Saturating increment for the stall counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic accept;
    logic held;

    assign id_ready = !ex_valid || ex_ready;
    assign accept   = id_valid && id_ready && !flush;
    assign held     = ex_valid && !ex_ready && !flush;

    // Valid bit: flush beats accept, accept beats the consume bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // Data fields: load on accept, otherwise hold with writeback refresh while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc   <= '0;
            ex_imm  <= '0;
            ex_ctrl <= '0;
            ex_rs1  <= '0;
            ex_rs2  <= '0;
            ex_rd   <= '0;
            ex_op1  <= '0;
            ex_op2  <= '0;
        end else if (accept) begin
            ex_pc   <= id_pc;
            ex_imm  <= id_imm;
            ex_ctrl <= id_ctrl;
            ex_rs1  <= id_rs1;
            ex_rs2  <= id_rs2;
            ex_rd   <= id_rd;
            ex_op1  <= fresh_operand(id_rs1, rf_rd1);
            ex_op2  <= fresh_operand(id_rs2, rf_rd2);
        end else if (held) begin
            if (wb_hits(wb_we, wb_rd, ex_rs1)) begin
                ex_op1 <= wb_data;
            end
            if (wb_hits(wb_we, wb_rd, ex_rs2)) begin
                ex_op2 <= wb_data;
            end
        end
    end

    // Stall counter: counts live-but-blocked cycles, survives flush, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (ex_valid && !ex_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: the bench plays the register file, and expected
// operands are the architectural register contents for the held indices.
module tb_id_ex_stage;

    localparam int CTRL_W = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              id_valid = 1'b0;
    logic              id_ready;
    logic [31:0]       id_pc = '0;
    logic [31:0]       id_imm = '0;
    logic [CTRL_W-1:0] id_ctrl = '0;
    logic [5:0]        id_rs1 = '0;
    logic [5:0]        id_rs2 = '0;
    logic [5:0]        id_rd = '0;
    logic [31:0]       rf_rd1 = '0;
    logic [31:0]       rf_rd2 = '0;
    logic              wb_we = 1'b0;
    logic [5:0]        wb_rd = '0;
    logic [31:0]       wb_data = '0;
    logic              ex_valid;
    logic              ex_ready = 1'b0;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [5:0]        ex_rs1;
    logic [5:0]        ex_rs2;
    logic [5:0]        ex_rd;
    logic [31:0]       ex_op1;
    logic [31:0]       ex_op2;
    logic [CNT_W-1:0]  stall_cnt;

    id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference state: architectural registers plus the instruction in the slot.
    logic [31:0]       regs [32];
    logic              m_valid;
    logic [31:0]       m_pc;
    logic [31:0]       m_imm;
    logic [CTRL_W-1:0] m_ctrl;
    logic [5:0]        m_rs1;
    logic [5:0]        m_rs2;
    logic [5:0]        m_rd;
    logic [CNT_W-1:0]  m_cnt;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc = '0; m_imm = '0; m_ctrl = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_cnt = '0;
    endtask

    // Applies one clock edge to the reference, using the inputs currently driven.
    task automatic model_edge();
        if (m_valid && !ex_ready && m_cnt != {CNT_W{1'b1}}) m_cnt++;
        if (flush) begin
            m_valid = 1'b0;
        end else if (id_valid && (!m_valid || ex_ready)) begin
            m_valid = 1'b1;
            m_pc = id_pc; m_imm = id_imm; m_ctrl = id_ctrl;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
        end else if (ex_ready) begin
            m_valid = 1'b0;
        end
        if (wb_we && wb_rd[4:0] != 5'd0) regs[wb_rd[4:0]] = wb_data;
    endtask

    task automatic check_outputs();
        chk("ex_valid", 64'(ex_valid), 64'(m_valid));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (m_valid) begin
            chk("ex_pc", 64'(ex_pc), 64'(m_pc));
            chk("ex_imm", 64'(ex_imm), 64'(m_imm));
            chk("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
            chk("ex_rs1", 64'(ex_rs1), 64'(m_rs1));
            chk("ex_rs2", 64'(ex_rs2), 64'(m_rs2));
            chk("ex_rd", 64'(ex_rd), 64'(m_rd));
            chk("ex_op1", 64'(ex_op1), 64'(regs[m_rs1[4:0]]));
            chk("ex_op2", 64'(ex_op2), 64'(regs[m_rs2[4:0]]));
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1 chk("id_ready", 64'(id_ready), 64'(!m_valid || ex_ready));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic offer(input logic [31:0] pc, input logic [5:0] rs1,
                         input logic [5:0] rs2, input logic [5:0] rd);
        id_valid = 1'b1;
        id_pc = pc; id_imm = ~pc; id_ctrl = pc[15:0] ^ 16'h5A5A;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        rf_rd1 = regs[rs1[4:0]];
        rf_rd2 = regs[rs2[4:0]];
    endtask

    task automatic quiet();
        id_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        quiet();
        ex_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 64'(ex_valid), 64'd0);
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_op1", 64'(ex_op1), 64'd0);
        chk("rst_ready", 64'(id_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [5:0] pick_idx();
        logic [5:0] v;
        v[5]   = 1'($urandom_range(0, 1));
        v[4:0] = 5'($urandom_range(0, 3));
        return v;
    endfunction

    logic [CNT_W-1:0] saved_cnt;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
        model_reset();
        do_reset();

        // Idle after reset release.
        quiet();
        step();
        chk("idle_valid", 64'(ex_valid), 64'd0);

        // Same-edge writeback bypass, and x0 never bypassed.
        regs[5] = 32'h11;
        offer(32'h40, 6'd5, 6'd0, 6'd1);
        ex_ready = 1'b1;
        wb_we = 1'b1; wb_rd = 6'd5; wb_data = 32'hAA;
        step();
        chk("bypass_op1", 64'(ex_op1), 64'hAA);
        offer(32'h44, 6'd0, 6'd0, 6'd2);
        wb_we = 1'b1; wb_rd = 6'd0; wb_data = 32'hAA;
        step();
        chk("x0_op1", 64'(ex_op1), 64'd0);

        // Three-cycle stall with refresh of a held operand.
        do_reset();
        quiet();
        ex_ready = 1'b1;
        offer(32'h200, 6'd3, 6'd7, 6'd9);
        step();
        offer(32'h204, 6'd1, 6'd2, 6'd3);
        ex_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            wb_we = (c == 2);
            wb_rd = 6'd7; wb_data = 32'h1234;
            step();
            chk("stall_ready", 64'(id_ready), 64'd0);
            chk("stall_pc", 64'(ex_pc), 64'h200);
        end
        chk("stall_op2", 64'(ex_op2), 64'h1234);
        chk("stall_cnt3", 64'(stall_cnt), 64'd3);

        // Flush while stalled with a new offer: nothing captured, counter kept.
        saved_cnt = stall_cnt;
        wb_we = 1'b0;
        flush = 1'b1;
        offer(32'hDEAD, 6'd1, 6'd1, 6'd1);
        step();
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_cnt", 64'(stall_cnt), 64'(saved_cnt) + 64'd1);
        quiet();
        step();
        chk("flush_nocap", 64'(ex_valid), 64'd0);

        // Back-to-back stream of four instructions.
        ex_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer(32'h300 + 32'(4 * k), 6'd1, 6'd2, 6'd4);
            step();
            chk("stream_valid", 64'(ex_valid), 64'd1);
            chk("stream_pc", 64'(ex_pc), 64'h300 + 64'(4 * k));
        end
        quiet();
        step();
        chk("stream_drain", 64'(ex_valid), 64'd0);

        // Asynchronous reset in the middle of a stall.
        do_reset();
        quiet();
        ex_ready = 1'b1;
        offer(32'h500, 6'd1, 6'd2, 6'd3);
        step();
        quiet();
        ex_ready = 1'b0;
        repeat (5) step();
        chk("pre_arst_cnt", 64'(stall_cnt), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ex_valid), 64'd0);
        chk("arst_cnt", 64'(stall_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference.
        for (int n = 0; n < 400; n++) begin
            offer($urandom, pick_idx(), pick_idx(), pick_idx());
            id_valid = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 9) == 0);
            ex_ready = ($urandom_range(0, 9) < 6);
            wb_we    = 1'($urandom_range(0, 1));
            wb_rd    = pick_idx();
            wb_data  = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
